// File: rtl/sbox_arb_pkg.sv
// Shared constants, tag type and dual round-robin pick function for the
// masked S-box BRAM arbiter.
package sbox_arb_pkg;

  localparam int unsigned SBOX_ADDR_W  = 10;
  localparam int unsigned SBOX_DATA_W  = 8;
  localparam int unsigned SBOX_RD_LAT  = 2;
  localparam int unsigned SBOX_MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } sbox_tag_t;

  typedef struct packed {
    logic       a_v;
    logic [2:0] a_idx;
    logic       b_v;
    logic [2:0] b_idx;
  } sbox_pick2_t;

  // Scan n requesters from ptr with wrap; first hit goes to port A, second to B.
  function automatic sbox_pick2_t rr_pick2(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
    sbox_pick2_t p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 0; k < SBOX_MAX_REQ; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (req[idx[2:0]]) begin
          if (!p.a_v) begin
            p.a_v   = 1'b1;
            p.a_idx = idx[2:0];
          end else if (!p.b_v) begin
            p.b_v   = 1'b1;
            p.b_idx = idx[2:0];
          end
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sbox_rr_pick2.sv
// Combinational dual round-robin picker: grants up to two requesters per
// cycle starting the scan at rr_ptr.
module sbox_rr_pick2
  import sbox_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       gnt_a_v,
  output logic [$clog2(NUM_REQ)-1:0] gnt_a_idx,
  output logic                       gnt_b_v,
  output logic [$clog2(NUM_REQ)-1:0] gnt_b_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sbox_pick2_t p;

  always_comb begin
    p         = rr_pick2(8'(req), 3'(rr_ptr), NUM_REQ);
    gnt_a_v   = p.a_v;
    gnt_a_idx = IDX_W'(p.a_idx);
    gnt_b_v   = p.b_v;
    gnt_b_idx = IDX_W'(p.b_idx);
  end

endmodule

// File: rtl/sbox_bram_arbiter.sv
// Shares one dual-port masked S-box BRAM among NUM_REQ requesters, routing
// results back by tag. Optional counters enabled by SBOX_ARB_STATS_EN.
module sbox_bram_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = SBOX_ADDR_W,
  parameter int unsigned DATA_W  = SBOX_DATA_W,
  parameter int unsigned RD_LAT  = SBOX_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]         bram_addra,
  output logic [ADDR_W-1:0]         bram_addrb,
  output logic                      bram_en,
  output logic                      bram_rst,
  input  logic [DATA_W-1:0]         bram_doa,
  input  logic [DATA_W-1:0]         bram_dob
`ifdef SBOX_ARB_STATS_EN
  ,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_stalls
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr, rr_nxt, last;
  logic             pa_v, pb_v, ga_v, gb_v;
  logic [IDX_W-1:0] pa_idx, pb_idx;
  sbox_tag_t        tag_a [RD_LAT];
  sbox_tag_t        tag_b [RD_LAT];

  sbox_rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .gnt_a_v   (pa_v),
    .gnt_a_idx (pa_idx),
    .gnt_b_v   (pb_v),
    .gnt_b_idx (pb_idx)
  );

  // Grants are masked while reset is held so nothing reaches the BRAM.
  assign ga_v     = pa_v & rst;
  assign gb_v     = pb_v & rst;
  assign bram_rst = ~rst;
  assign bram_en  = ga_v | gb_v | tag_a[0].valid | tag_b[0].valid;

  always_comb begin
    req_ready  = '0;
    bram_addra = '0;
    bram_addrb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ga_v && pa_idx == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        bram_addra   = req_addr[i*ADDR_W +: ADDR_W];
      end
      if (gb_v && pb_idx == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        bram_addrb   = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    last   = gb_v ? pb_idx : pa_idx;
    rr_nxt = (32'(last) == NUM_REQ - 1) ? '0 : last + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        tag_a[s] <= '0;
        tag_b[s] <= '0;
      end
    end else begin
      if (ga_v) rr_ptr <= rr_nxt;
      tag_a[0] <= {ga_v, ga_v ? 3'(pa_idx) : 3'd0};
      tag_b[0] <= {gb_v, gb_v ? 3'(pb_idx) : 3'd0};
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        tag_a[s] <= tag_a[s-1];
        tag_b[s] <= tag_b[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tag_a[RD_LAT-1].valid && tag_a[RD_LAT-1].id == 3'(i)) begin
        rsp_valid[i]                = 1'b1;
        rsp_data[i*DATA_W +: DATA_W] = bram_doa;
      end else if (tag_b[RD_LAT-1].valid && tag_b[RD_LAT-1].id == 3'(i)) begin
        rsp_valid[i]                = 1'b1;
        rsp_data[i*DATA_W +: DATA_W] = bram_dob;
      end
    end
  end

`ifdef SBOX_ARB_STATS_EN
  logic [1:0] ngrant;
  logic       stall;

  assign ngrant = {1'b0, ga_v} + {1'b0, gb_v};
  assign stall  = |(req_valid & ~req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (ngrant != 2'd0)
        stat_grants <= (stat_grants > ('1 - 32'(ngrant))) ? '1 : stat_grants + 32'(ngrant);
      if (stall && stat_stalls != '1)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_bram_arbiter.sv
// Scoreboard bench for sbox_bram_arbiter with a behavioural two-stage BRAM.
module tb_sbox_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [9:0]  la [4];
  logic [39:0] req_addr;
  logic [3:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [9:0]  bram_addra, bram_addrb, a_q, b_q;
  logic        bram_en, bram_rst;
  logic [7:0]  bram_doa, bram_dob;
`ifdef SBOX_ARB_STATS_EN
  logic [31:0] stat_grants, stat_stalls;
`endif

  typedef struct {
    int         lane;
    logic [7:0] data;
    int         due;
  } ent_t;

  ent_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mrr;

  assign req_addr = {la[3], la[2], la[1], la[0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_bram_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(8), .RD_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_en    (bram_en),
    .bram_rst   (bram_rst),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob)
`ifdef SBOX_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  function automatic logic [7:0] sbox(input logic [9:0] a);
    return (a[7:0] + {a[9:8], 6'b0}) ^ 8'h63;
  endfunction

  // Address register then output register, both gated by the shared enable.
  always @(posedge clk) begin
    if (bram_en) begin
      a_q <= bram_addra;
      b_q <= bram_addrb;
    end
    if (bram_rst) begin
      bram_doa <= '0;
      bram_dob <= '0;
    end else if (bram_en) begin
      bram_doa <= sbox(a_q);
      bram_dob <= sbox(b_q);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire responses due this cycle, then record this cycle's accepts.
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] ed;
    if (!rst) begin
      sbq.delete();
    end else begin
      ev = '0;
      ed = '0;
      for (int k = sbq.size() - 1; k >= 0; k--) begin
        if (sbq[k].due == cyc) begin
          ev[sbq[k].lane]             = 1'b1;
          ed[sbq[k].lane*8 +: 8]      = sbq[k].data;
          sbq.delete(k);
        end
      end
      check("rsp_valid", rsp_valid, ev);
      for (int i = 0; i < 4; i++)
        if (ev[i]) check("rsp_data", rsp_data[i*8 +: 8], ed[i*8 +: 8]);
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i])
          sbq.push_back('{lane: i, data: sbox(la[i]), due: cyc + 2});
    end
  end

  initial begin
    logic [3:0] ev, granted;
    logic [9:0] ea, eb;
    int         na, last, idx;

    rst       = 1'b0;
    req_valid = 4'hF;
    la        = '{10'h011, 10'h022, 10'h033, 10'h044};
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", req_ready, 4'h0);
    check("rst_rsp_valid", rsp_valid, 4'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_addra", bram_addra, 10'h0);
    check("rst_addrb", bram_addrb, 10'h0);
    check("rst_en", bram_en, 1'b0);
    check("rst_bram_rst", bram_rst, 1'b1);
    req_valid = 4'h0;
    tick();
    rst = 1'b1;
    tick();

    req_valid = 4'b0100; la[2] = 10'h1A3; #1;
    check("single_ready", req_ready, 4'b0100);
    check("single_addra", bram_addra, 10'h1A3);
    check("single_addrb", bram_addrb, 10'h000);
    check("single_en", bram_en, 1'b1);
    tick();
    req_valid = 4'b1001; la[0] = 10'h055; la[3] = 10'h2C7; #1;
    check("rr3_ready", req_ready, 4'b1001);
    check("rr3_addra", bram_addra, 10'h2C7);
    check("rr3_addrb", bram_addrb, 10'h055);
    tick();
    req_valid = 4'b0010; la[1] = 10'h10F; #1;
    check("rr1_ready", req_ready, 4'b0010);
    check("rr1_addra", bram_addra, 10'h10F);
    tick();
    req_valid = 4'b1010; la[1] = 10'h0B1; la[3] = 10'h3E8; #1;
    check("rr2_ready", req_ready, 4'b1010);
    check("rr2_addra", bram_addra, 10'h3E8);
    check("rr2_addrb", bram_addrb, 10'h0B1);
    tick();
    req_valid = 4'b1110; la[2] = 10'h222; la[3] = 10'h333; la[1] = 10'h111; #1;
    check("rr2b_ready", req_ready, 4'b1100);
    check("rr2b_addra", bram_addra, 10'h222);
    check("rr2b_addrb", bram_addrb, 10'h333);
    tick();

    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("full_ready", req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      check("full_addra", bram_addra, la[(k % 2 == 0) ? 0 : 2]);
      check("full_addrb", bram_addrb, la[(k % 2 == 0) ? 1 : 3]);
      granted = req_ready;
      tick();
      for (int i = 0; i < 4; i++) if (granted[i]) la[i] = 10'($urandom_range(0, 1023));
    end
    req_valid = 4'h0;
    repeat (3) tick();

    req_valid = 4'b0001; la[0] = 10'h000; #1;
    check("b2b_en0", bram_en, 1'b1);
    tick();
    la[0] = 10'h3FF; #1;
    check("b2b_en1", bram_en, 1'b1);
    tick();
    req_valid = 4'h0; #1;
    check("b2b_en2", bram_en, 1'b1);
    tick();
    check("b2b_en3", bram_en, 1'b0);
    repeat (2) tick();

    req_valid = 4'b0011; la[0] = 10'h0AA; la[1] = 10'h155; #1;
    check("mid_ready", req_ready, 4'b0011);
    check("mid_addra", bram_addra, 10'h155);
    tick();
    req_valid = 4'h0;
    rst = 1'b0; #1;
    check("mid_rst_rsp", rsp_valid, 4'h0);
    check("mid_rst_en", bram_en, 1'b0);
    check("mid_rst_addra", bram_addra, 10'h0);
    check("mid_rst_bram_rst", bram_rst, 1'b1);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    req_valid = 4'b1010; la[1] = 10'h0C3; la[3] = 10'h23C; #1;
    check("post_rst_ready", req_ready, 4'b1010);
    check("post_rst_addra", bram_addra, 10'h0C3);
    check("post_rst_addrb", bram_addrb, 10'h23C);
    tick();
    req_valid = 4'h0;
`ifdef SBOX_ARB_STATS_EN
    check("stat_grants0", stat_grants, 32'd2);
    check("stat_stalls0", stat_stalls, 32'd0);
    req_valid = 4'b0111; #1;
    tick();
    req_valid = 4'h0;
    check("stat_grants1", stat_grants, 32'd4);
    check("stat_stalls1", stat_stalls, 32'd1);
`endif
    repeat (3) tick();

    rst = 1'b0;
    tick();
    rst = 1'b1;
    mrr = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          la[i]        = 10'($urandom_range(0, 1023));
        end
      #1;
      ev = '0; ea = '0; eb = '0; na = 0; last = mrr;
      for (int k = 0; k < 4; k++) begin
        idx = (mrr + k) % 4;
        if (req_valid[idx] && na < 2) begin
          ev[idx] = 1'b1;
          if (na == 0) ea = la[idx];
          else         eb = la[idx];
          na++;
          last = idx;
        end
      end
      if (na != 0) mrr = (last + 1) % 4;
      check("rnd_ready", req_ready, ev);
      check("rnd_addra", bram_addra, ea);
      check("rnd_addrb", bram_addrb, eb);
      granted = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~granted;
    end
    req_valid = 4'h0;
    repeat (4) tick();
    check("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
